// File: rtl/acondicionador_botones_rtc.sv
// Button/switch conditioning for the RTC control block: 2-FF sync,
// debounce, press pulses with UP/DOWN auto-repeat, debounced switches.
module acondicionador_botones_rtc #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_right,
    input  logic btn_left,
    input  logic btn_center,
    input  logic sw1_raw,
    input  logic sw2_raw,
    output logic enUP,
    output logic enDOWN,
    output logic enRIGHT,
    output logic enLEFT,
    output logic desactivar_alarma,
    output logic sw1,
    output logic sw2
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                             DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;

    localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LIM  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LIM = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (CNT_W < $clog2(MAX_CNT + 1)) begin : g_cnt_w_chk
        $error("CNT_W too narrow for the configured counts");
    end

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        REPEAT,
        DEB_RELEASE
    } btn_state_e;

    // bit order: up, down, right, left, center, sw1, sw2
    logic [6:0] raw;
    logic [6:0] sync1_q;
    logic [6:0] sync2_q;

    assign raw = {sw2_raw, sw1_raw, btn_center,
                  btn_left, btn_right, btn_down, btn_up};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    logic [4:0] cand;

    for (genvar g = 0; g < 5; g++) begin : g_btn
        localparam bit REP = (g < 2);

        btn_state_e       state_q;
        btn_state_e       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             pulse_q;
        logic             pulse_d;
        logic             s;

        assign s       = sync2_q[g];
        assign cand[g] = pulse_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (s) state_d = DEB_PRESS;
                end
                DEB_PRESS: begin
                    if (!s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LIM) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_d = DEB_RELEASE;
                        cnt_d   = '0;
                    end else if (REP && cnt_q == DLY_LIM) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else if (cnt_q != DLY_LIM) begin
                        // non-repeating keys park at the limit
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (!s) begin
                        state_d = DEB_RELEASE;
                        cnt_d   = '0;
                    end else if (cnt_q == RATE_LIM) begin
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                DEB_RELEASE: begin
                    if (s) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LIM) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // losers of a same-cycle collision are dropped, not queued
    logic [3:0] dir_d;
    logic [3:0] dir_q;
    logic       alarm_q;

    always_comb begin
        dir_d = '0;
        if (cand[0])      dir_d = 4'b0001;
        else if (cand[1]) dir_d = 4'b0010;
        else if (cand[2]) dir_d = 4'b0100;
        else if (cand[3]) dir_d = 4'b1000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            dir_q   <= dir_d;
            alarm_q <= cand[4];
        end
    end

    logic [1:0] sw_lvl;

    for (genvar k = 0; k < 2; k++) begin : g_sw
        logic             lvl_q;
        logic             lvl_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             s;

        assign s         = sync2_q[5+k];
        assign sw_lvl[k] = lvl_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                lvl_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                lvl_q <= lvl_d;
                cnt_q <= cnt_d;
            end
        end

        always_comb begin
            lvl_d = lvl_q;
            cnt_d = cnt_q;
            if (s == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_q == DEB_LIM) begin
                lvl_d = s;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    assign enUP              = dir_q[0];
    assign enDOWN            = dir_q[1];
    assign enRIGHT           = dir_q[2];
    assign enLEFT            = dir_q[3];
    assign desactivar_alarma = alarm_q;
    assign sw1               = sw_lvl[0];
    assign sw2               = sw_lvl[1];

endmodule
